// File: rtl/namuru_fetch_pkg.sv
// ---------------------------------------------------------------------------
// namuru_fetch_pkg
//   Shared types and constants for the accumulator fetch engine.
//   - fetch_state_t : FSM states (TS exists only when the build-time macro
//                     NAMURU_FETCH_TIMESTAMP_EN is defined)
//   - WB_SEL_ALL    : byte-select used for every read
//   - IDX_W         : internal word-index width (one spare bit so the
//                     timestamped dump can count to NWORDS=256)
// ---------------------------------------------------------------------------
package namuru_fetch_pkg;

`ifdef NAMURU_FETCH_TIMESTAMP_EN
    typedef enum logic [1:0] {IDLE, REQ, OUT, TS} fetch_state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, OUT} fetch_state_t;
`endif

    localparam logic [3:0] WB_SEL_ALL = 4'hF;
    localparam int         IDX_W      = 9;

endpackage

// File: rtl/namuru_fetch_watchdog.sv
// ---------------------------------------------------------------------------
// namuru_fetch_watchdog
//   Bus-read watchdog. Counts cycles of an outstanding strobe and flags
//   expiry on the TIMEOUT-th unacknowledged cycle.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     clear      : reload the counter to zero (has priority over run)
//     run        : strobe outstanding and not acknowledged this cycle
//     expired    : high in the TIMEOUT-th consecutive run cycle
// ---------------------------------------------------------------------------
module namuru_fetch_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int            CW    = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + 1'b1;
        end
    end

    // cnt holds the number of run cycles already elapsed, so the cycle in
    // which it reaches TIMEOUT-1 is the TIMEOUT-th one.
    assign expired = run && (cnt == LIMIT);

endmodule

// File: rtl/namuru_accum_fetch.sv
// ---------------------------------------------------------------------------
// namuru_accum_fetch
//   Wishbone read master that drains NWORDS correlator accumulator registers
//   on every rising edge of accum_int and streams them out as valid/ready
//   words. Optional macro NAMURU_FETCH_TIMESTAMP_EN prepends a word holding a
//   free-running cycle count captured at the accepted trigger.
//
//   Stream handshake: a word transfers in any cycle where smp_valid and
//   smp_ready are both high at the rising clock edge; while smp_valid is
//   high and smp_ready low, smp_data/smp_index/smp_last stay unchanged.
//   smp_valid never depends combinationally on smp_ready.
//
//   Ports:
//     sys_clk, sys_rst_n     : clock, asynchronous active-low reset
//     enable                 : accept triggers; low aborts and clears status
//     accum_int              : accumulation interrupt (level)
//     wb_*                   : Wishbone classic read master
//     smp_data/index/last    : stream payload
//     smp_valid / smp_ready  : stream handshake
//     busy                   : FSM not in IDLE
//     overrun_cnt            : saturating count of triggers dropped while busy
//     timeout_err            : sticky bus-timeout flag
// ---------------------------------------------------------------------------
module namuru_accum_fetch
    import namuru_fetch_pkg::*;
#(
    parameter logic [31:0] BASE_ADR   = 32'h0000_0000,
    parameter int          NWORDS     = 16,
    parameter int          ADR_STRIDE = 4,
    parameter int          TIMEOUT    = 255
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        enable,
    input  logic        accum_int,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    output logic        wb_we_o,
    input  logic        wb_ack_i,
    output logic [31:0] smp_data,
    output logic [7:0]  smp_index,
    output logic        smp_last,
    output logic        smp_valid,
    input  logic        smp_ready,
    output logic        busy,
    output logic [7:0]  overrun_cnt,
    output logic        timeout_err
);

`ifdef NAMURU_FETCH_TIMESTAMP_EN
    // Timestamp occupies index 0, so register words run 1..NWORDS.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS);
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
`endif

    fetch_state_t     state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [IDX_W-1:0] word_idx;
    logic             accum_q;
    logic             enable_q;
    logic             trig;
    logic             accept;
    logic             in_req;
    logic             wd_expired;

    assign trig   = accum_int & ~accum_q;
    // enable_q keeps a trigger that coincides with enable rising from
    // starting a dump.
    assign accept = trig & enable & enable_q;
    assign in_req = (state == REQ);

    namuru_fetch_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .clear   (!in_req || wb_ack_i),
        .run     (in_req && !wb_ack_i),
        .expired (wd_expired)
    );

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (accept) begin
                    idx_nxt = '0;
`ifdef NAMURU_FETCH_TIMESTAMP_EN
                    state_nxt = TS;
`else
                    state_nxt = REQ;
`endif
                end
            end
`ifdef NAMURU_FETCH_TIMESTAMP_EN
            TS: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (smp_ready) begin
                    idx_nxt   = 1;
                    state_nxt = REQ;
                end
            end
`endif
            REQ: begin
                // An open bus cycle always runs to ack or timeout; a word
                // fetched after enable dropped is simply not presented.
                if (wb_ack_i) begin
                    state_nxt = enable ? OUT : IDLE;
                end else if (wd_expired) begin
                    state_nxt = IDLE;
                end
            end
            OUT: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (smp_ready) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = REQ;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef NAMURU_FETCH_TIMESTAMP_EN
    logic [31:0] ts_cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
        end
    end

    assign word_idx = idx - 1'b1;
`else
    assign word_idx = idx;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            accum_q     <= 1'b0;
            enable_q    <= 1'b0;
            smp_data    <= '0;
            overrun_cnt <= '0;
            timeout_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            accum_q  <= accum_int;
            enable_q <= enable;

            if (in_req && wb_ack_i) begin
                smp_data <= wb_dat_i;
            end
`ifdef NAMURU_FETCH_TIMESTAMP_EN
            else if (state == IDLE && accept) begin
                smp_data <= ts_cnt;
            end
`endif

            if (!enable) begin
                overrun_cnt <= '0;
            end else if (trig && state != IDLE && overrun_cnt != 8'hFF) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end

            if (!enable) begin
                timeout_err <= 1'b0;
            end else if (wd_expired) begin
                timeout_err <= 1'b1;
            end
        end
    end

    // Bus outputs decode straight from the state register so an
    // asynchronous reset removes cyc/stb immediately.
    assign wb_cyc_o = in_req;
    assign wb_stb_o = in_req;
    assign wb_sel_o = in_req ? WB_SEL_ALL : 4'h0;
    assign wb_adr_o = in_req ? (BASE_ADR + 32'(word_idx) * 32'(ADR_STRIDE)) : 32'h0;
    assign wb_dat_o = 32'h0;
    assign wb_we_o  = 1'b0;

`ifdef NAMURU_FETCH_TIMESTAMP_EN
    assign smp_valid = (state == OUT) || (state == TS);
`else
    assign smp_valid = (state == OUT);
`endif
    assign smp_last  = (state == OUT) && (idx == LAST_IDX);
    assign smp_index = idx[7:0];
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_namuru_accum_fetch.sv
// ---------------------------------------------------------------------------
// tb_namuru_accum_fetch
//   Bench for namuru_accum_fetch with NWORDS=4, BASE_ADR=0x100, stride 4,
//   TIMEOUT=8. The slave returns 0xDA7A0000 | address as read data.
// ---------------------------------------------------------------------------
module tb_namuru_accum_fetch;

    localparam logic [31:0] BASE   = 32'h0000_0100;
    localparam int          NW     = 4;
    localparam int          STRIDE = 4;
    localparam int          TO     = 8;
    localparam logic [31:0] DTAG   = 32'hDA7A_0000;

    logic        clk = 1'b0;
    logic        sys_rst_n;
    logic        enable;
    logic        accum_int;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic        wb_we_o;
    logic        wb_ack_i;
    logic [31:0] smp_data;
    logic [7:0]  smp_index;
    logic        smp_last;
    logic        smp_valid;
    logic        smp_ready;
    logic        busy;
    logic [7:0]  overrun_cnt;
    logic        timeout_err;

    // scoreboard: {last, index, data} and expected bus addresses
    logic [40:0] exp_q[$];
    logic [31:0] adr_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int tb_cyc   = 0;
    logic ack_en = 1'b1;

    namuru_accum_fetch #(
        .BASE_ADR   (BASE),
        .NWORDS     (NW),
        .ADR_STRIDE (STRIDE),
        .TIMEOUT    (TO)
    ) dut (
        .sys_clk     (clk),
        .sys_rst_n   (sys_rst_n),
        .enable      (enable),
        .accum_int   (accum_int),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_dat_i    (wb_dat_i),
        .wb_sel_o    (wb_sel_o),
        .wb_stb_o    (wb_stb_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_we_o     (wb_we_o),
        .wb_ack_i    (wb_ack_i),
        .smp_data    (smp_data),
        .smp_index   (smp_index),
        .smp_last    (smp_last),
        .smp_valid   (smp_valid),
        .smp_ready   (smp_ready),
        .busy        (busy),
        .overrun_cnt (overrun_cnt),
        .timeout_err (timeout_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            if (!sys_rst_n) tb_cyc = 0;
            else            tb_cyc = tb_cyc + 1;
        end
    end

    // ---------------- helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: event with empty expectation queue", name);
    endtask

    task automatic push_word(input int idx, input logic last, input logic [31:0] data);
        exp_q.push_back({last, 8'(idx), data});
    endtask

    // Register dump: words 0..NW-1 at index first_idx.., last on final one.
    task automatic push_dump(input int first_idx);
        for (int i = 0; i < NW; i++) begin
            adr_q.push_back(BASE + 32'(i * STRIDE));
            push_word(first_idx + i, (i == NW - 1), DTAG | (BASE + 32'(i * STRIDE)));
        end
    endtask

    task automatic pulse;
        accum_int = 1'b1;
        step(1);
        accum_int = 1'b0;
        step(1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 300) begin
            step(1);
            n++;
        end
        check(name, busy, 1'b0);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!smp_valid && n < 100) begin
            step(1);
            n++;
        end
        check(name, smp_valid, 1'b1);
    endtask

    // ---------------- bus slave: acks the cycle after stb appears ----------------
    initial begin
        logic prev_stb = 1'b0;
        logic prev_ack = 1'b0;
        logic ack;
        wb_ack_i = 1'b0;
        wb_dat_i = '0;
        forever begin
            @(posedge clk);
            #1;
            ack      = ack_en && wb_stb_o && prev_stb && !prev_ack;
            prev_stb = wb_stb_o;
            prev_ack = ack;
            wb_ack_i = ack;
            wb_dat_i = ack ? (DTAG | wb_adr_o) : 32'h0;
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (sys_rst_n) begin
                if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
                    if (adr_q.size() == 0) fail_now("bus_ack");
                    else check("bus_adr", wb_adr_o, adr_q.pop_front());
                end
                if (smp_valid && smp_ready) begin
                    if (exp_q.size() == 0) fail_now("stream_word");
                    else check("stream_word", {smp_last, smp_index, smp_data}, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        sys_rst_n = 1'b0;
        enable    = 1'b0;
        accum_int = 1'b0;
        smp_ready = 1'b0;
        step(2);

        // reset state
        check("rst_bus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o}, 64'h0);
        check("rst_stream", {smp_valid, smp_last, smp_index, smp_data}, 64'h0);
        check("rst_status", {busy, timeout_err, overrun_cnt}, 64'h0);
        sys_rst_n = 1'b1;
        step(1);

`ifdef NAMURU_FETCH_TIMESTAMP_EN
        // timestamp word captured at counter 1000, then NW register words
        enable    = 1'b1;
        smp_ready = 1'b1;
        while (tb_cyc < 1000) step(1);
        push_word(0, 1'b0, 32'd1000);
        push_dump(1);
        accum_int = 1'b1;
        step(1);
        accum_int = 1'b0;
        check("ts_no_bus", {wb_stb_o, smp_valid, smp_index}, {1'b0, 1'b1, 8'd0});
        wait_idle("ts_done");
        check("ts_queue_empty", exp_q.size(), 0);
`else
        // 1: basic dump, latency
        enable    = 1'b1;
        smp_ready = 1'b1;
        step(2);
        push_dump(0);
        accum_int = 1'b1;
        step(1);
        accum_int = 1'b0;
        check("t1_stb_latency", {wb_stb_o, wb_cyc_o, wb_sel_o, wb_adr_o}, {1'b1, 1'b1, 4'hF, BASE});
        step(1);
        check("t1_ack_cycle", {wb_stb_o, smp_valid}, {1'b1, 1'b0});
        step(1);
        check("t1_valid_latency", {wb_stb_o, smp_valid, smp_index}, {1'b0, 1'b1, 8'd0});
        wait_idle("t1_done");
        check("t1_queue_empty", exp_q.size(), 0);

        // 2: back-pressure on word 1
        smp_ready = 1'b0;
        push_dump(0);
        pulse();
        wait_valid("t2_word0");
        smp_ready = 1'b1;
        step(1);
        smp_ready = 1'b0;
        wait_valid("t2_word1");
        for (int k = 0; k < 10; k++) begin
            check("t2_hold", {wb_stb_o, smp_valid, smp_last, smp_index, smp_data},
                  {1'b0, 1'b1, 1'b0, 8'd1, DTAG | (BASE + 32'd4)});
            step(1);
        end
        smp_ready = 1'b1;
        wait_idle("t2_done");

        // 3: overrun counting and saturation
        smp_ready = 1'b0;
        push_dump(0);
        pulse();
        pulse();
        check("t3_overrun_1", overrun_cnt, 8'd1);
        repeat (300) pulse();
        check("t3_overrun_sat", {busy, overrun_cnt}, {1'b1, 8'hFF});
        smp_ready = 1'b1;
        wait_idle("t3_done");
        check("t3_overrun_hold", overrun_cnt, 8'hFF);

        // 4: slave never acks
        ack_en    = 1'b0;
        accum_int = 1'b1;
        step(1);
        accum_int = 1'b0;
        n = 0;
        while (wb_stb_o && n < 50) begin
            n++;
            step(1);
        end
        check("t4_stb_cycles", n, TO);
        check("t4_status", {busy, timeout_err}, {1'b0, 1'b1});
        enable = 1'b0;
        step(1);
        check("t4_cleared", {timeout_err, overrun_cnt}, 64'h0);
        ack_en = 1'b1;

        // 5a: enable drops during REQ: bus completes, word discarded
        enable = 1'b1;
        step(2);
        adr_q.push_back(BASE);
        accum_int = 1'b1;
        step(1);
        accum_int = 1'b0;
        enable    = 1'b0;
        step(3);
        check("t5a_idle", {busy, smp_valid, wb_cyc_o, timeout_err, overrun_cnt}, 64'h0);

        // triggers while disabled do nothing
        pulse();
        step(1);
        check("t5_disabled_trig", {busy, wb_stb_o}, 64'h0);

        // 5b: enable drops during OUT: valid abandoned next cycle
        enable = 1'b1;
        step(2);
        smp_ready = 1'b0;
        adr_q.push_back(BASE);
        pulse();
        wait_valid("t5b_word0");
        enable = 1'b0;
        step(1);
        check("t5b_idle", {busy, smp_valid, wb_stb_o, timeout_err, overrun_cnt}, 64'h0);

        // trigger coincident with enable rising is ignored
        enable    = 1'b1;
        accum_int = 1'b1;
        step(1);
        accum_int = 1'b0;
        check("t5_enable_edge_trig", {busy, wb_stb_o}, 64'h0);
        step(2);

        check("adr_queue_empty", adr_q.size(), 0);
        check("final_queue_empty", exp_q.size(), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
